dsa_scan_scheduler: RTL and testbench
=====================================

# dsa_scan_scheduler

Sequencer that drives the SIMD bilinear pixel-fetch unit across a whole output image. On `start` it computes the destination dimensions from the source size and integer scale factor, walks the destination raster in groups of SIMD_WIDTH pixels, and issues one fetch request per group. It then waits for the fetch unit's completion and presents each group's coordinates and lane mask to the downstream interpolation/writeback stage under a valid/ready handshake.

## Interface
- SIMD_WIDTH, 4, pixels per fetch group; power of two, 2..8
- DIM_WIDTH, 16, width of coordinate and dimension fields
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle job start; ignored unless idle
- abort  in  1  one-cycle request to terminate the current job
- src_width, src_height  in  DIM_WIDTH  source image size in pixels
- scale_factor  in  8  integer upscale factor
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end (normal, abort or error)
- err_cfg  out  1  one-cycle pulse coincident with `done` on configuration error
- fetch_req_valid  out  1  one-cycle request to the fetch unit
- fetch_base_x, fetch_base_y  out  DIM_WIDTH  destination coordinates of the group's lane 0
- fetch_busy  in  1  fetch unit busy
- fetch_valid  in  1  fetch unit group complete (one-cycle pulse)
- out_valid  out  1  group ready for the downstream stage
- out_ready  in  1  downstream accepts
- out_x, out_y  out  DIM_WIDTH  group coordinates (lane 0)
- out_lane_mask  out  SIMD_WIDTH  bit i set iff out_x+i < dst_w
- out_last  out  1  final group of the job
- perf_active_cycles, perf_stall_cycles  out  32  performance counters (see Configuration)

## Operation
- States: IDLE, CHECK, ISSUE, WAIT, EMIT, DONE.
- IDLE: on `start`, latch src_width, src_height and scale_factor, then go to CHECK. Inputs are not re-sampled for the rest of the job.
- CHECK (1 cycle): compute dst_w = src_width*scale_factor and dst_h = src_height*scale_factor as 24-bit products. If scale = 0, either source dimension = 0, or either product has bits [23:DIM_WIDTH] ≠ 0, set the error flag and go to DONE. Otherwise set x = y = 0 and go to ISSUE.
- ISSUE: while `fetch_busy` is high, stay with `fetch_req_valid` low. When `fetch_busy` is low, assert `fetch_req_valid` with base = (x, y) and go to WAIT.
- WAIT: on `fetch_valid`, go to EMIT. The scheduler makes no assumption about fetch latency.
- EMIT: hold `out_valid` with coordinates, mask and `out_last` stable until `out_ready` is high.
  - On acceptance with out_last = 1, go to DONE.
  - Otherwise advance: if x+SIMD_WIDTH ≥ dst_w, set x = 0 and y = y+1; else x = x+SIMD_WIDTH. Then go to ISSUE.
- out_last = (y == dst_h-1) && (x+SIMD_WIDTH ≥ dst_w).
- DONE: pulse `done`, plus `err_cfg` if the error flag is set; clear the flag; go to IDLE.
- abort:
  - In CHECK, ISSUE or EMIT: go to DONE next cycle. In EMIT, `out_valid` drops without a transfer.
  - In WAIT: latch a pending abort. On `fetch_valid`, go to DONE instead of EMIT, because the fetch unit cannot be cancelled.
  - In IDLE or DONE: ignored.
- If `start` and `abort` arrive in the same cycle in IDLE, `start` wins.
- A partial last column group (dst_w not a multiple of SIMD_WIDTH) issues normally; out-of-range lanes are masked.

## Timing
- All outputs are registered or Moore-decoded from state and registers. There are no combinational paths from `out_ready`/`fetch_valid` to outputs, except that `fetch_req_valid` = ISSUE && !fetch_busy.
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-job returns to IDLE immediately. The fetch unit shares `rst`.
- Latency:
  - `start` sampled at edge T: CHECK during T+1, ISSUE during T+2, and `fetch_req_valid` during T+2 if the fetch unit is not busy.
  - `fetch_valid` at edge F: `out_valid` during F+1.
  - Acceptance at edge A: next ISSUE during A+1.
- EMIT lasts ≥ 1 cycle, which guarantees the fetch unit has returned to idle before the next request.
- Per-group overhead beyond fetch latency: 2 cycles with `out_ready` held high.

## Configuration
- DSA_SCAN_PERF_EN defined:
  - perf_active_cycles counts cycles with busy = 1.
  - perf_stall_cycles counts EMIT cycles with out_ready = 0.
  - Both clear on `start`, saturate at 2^32-1, and hold after the job.
- DSA_SCAN_PERF_EN undefined: both ports are present and tied to 0, and no counter logic is built.

## Structure
- Shared package dsa_sched_pkg holds:
  - the state enum (sched_state_t)
  - DIM_WIDTH_DEF = 16
  - the 24-bit product width constant
- One sub-module, dsa_raster_walker, holds the x/y counters, wrap logic, lane-mask and out_last generation, with advance/clear inputs.
- The scheduler FSM, CHECK arithmetic and perf counters live in the top module.

## Test plan
- src 4×2, scale 2, out_ready = 1, fetch model with 20-cycle latency -> dst 8×4; 8 groups at (0,0), (4,0) … (4,3); all masks 4'b1111; out_last only on (4,3); then one `done`, err_cfg = 0.
- src 3×1, scale 2 -> dst 6×2; groups (0,0) mask 1111, (4,0) mask 0011, (0,1) mask 1111, (4,1) mask 0011 with out_last.
- scale 0, then src_width 0, then src_width 0x8000 with scale 2 -> each gives done + err_cfg two cycles after `start`, with no `fetch_req_valid`.
- out_ready low for 5 cycles on group 2 -> outputs held stable; perf_stall_cycles = 5 with DSA_SCAN_PERF_EN.
- `abort` during WAIT -> no `out_valid`; `done` the cycle after `fetch_valid`. `abort` during EMIT -> `done` next cycle.
- `rst` asserted mid-job, and `fetch_busy` held high in ISSUE -> immediate IDLE with all outputs 0; no request issues until `fetch_busy` falls.

Source files
------------

// File: rtl/dsa_sched_pkg.sv
// Shared types and constants for the scan scheduler slice.
package dsa_sched_pkg;

  localparam int DIM_WIDTH_DEF = 16;
  localparam int SCALE_WIDTH   = 8;
  localparam int PROD_WIDTH    = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_EMIT,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/dsa_scan_scheduler_if.sv
// Fetch-unit request/response and downstream group handshake for the scan scheduler.
interface dsa_scan_scheduler_if #(
  parameter int SIMD_WIDTH = 4,
  parameter int DIM_WIDTH  = 16
);
  logic                  fetch_req_valid;
  logic [DIM_WIDTH-1:0]  fetch_base_x;
  logic [DIM_WIDTH-1:0]  fetch_base_y;
  logic                  fetch_busy;
  logic                  fetch_valid;

  logic                  out_valid;
  logic                  out_ready;
  logic [DIM_WIDTH-1:0]  out_x;
  logic [DIM_WIDTH-1:0]  out_y;
  logic [SIMD_WIDTH-1:0] out_lane_mask;
  logic                  out_last;

  modport master (
    output fetch_req_valid, fetch_base_x, fetch_base_y,
    input  fetch_busy, fetch_valid,
    output out_valid, out_x, out_y, out_lane_mask, out_last,
    input  out_ready
  );

  modport slave (
    input  fetch_req_valid, fetch_base_x, fetch_base_y,
    output fetch_busy, fetch_valid,
    input  out_valid, out_x, out_y, out_lane_mask, out_last,
    output out_ready
  );
endinterface

// File: rtl/dsa_raster_walker.sv
// Destination raster position: x/y group counters with row wrap, lane mask and last-group flag.
module dsa_raster_walker #(
  parameter int SIMD_WIDTH = 4,
  parameter int DIM_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  advance,
  input  logic [DIM_WIDTH-1:0]  dst_w,
  input  logic [DIM_WIDTH-1:0]  dst_h,
  output logic [DIM_WIDTH-1:0]  x,
  output logic [DIM_WIDTH-1:0]  y,
  output logic [SIMD_WIDTH-1:0] lane_mask,
  output logic                  last
);

  localparam logic [DIM_WIDTH:0] STEP = (DIM_WIDTH+1)'(SIMD_WIDTH);

  // One guard bit so x+SIMD_WIDTH near the top of the range cannot wrap.
  logic [DIM_WIDTH:0] x_ext;
  logic [DIM_WIDTH:0] w_ext;
  logic [DIM_WIDTH:0] x_step;
  logic               row_end;

  assign x_ext   = {1'b0, x};
  assign w_ext   = {1'b0, dst_w};
  assign x_step  = x_ext + STEP;
  assign row_end = (x_step >= w_ext);
  assign last    = row_end && (y == dst_h - DIM_WIDTH'(1));

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < SIMD_WIDTH; i++) begin
      lane_mask[i] = ((x_ext + (DIM_WIDTH+1)'(i)) < w_ext);
    end
  end

  // NOTE: registers use non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (row_end) begin
        x <= '0;
        y <= y + DIM_WIDTH'(1);
      end else begin
        x <= x_step[DIM_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/dsa_scan_scheduler.sv
// Scan scheduler FSM: walks the upscaled raster in SIMD groups, drives fetch and hands groups downstream.
// Optional performance counters are built only when DSA_SCAN_PERF_EN is defined.
module dsa_scan_scheduler
  import dsa_sched_pkg::*;
#(
  parameter int SIMD_WIDTH = 4,
  parameter int DIM_WIDTH  = DIM_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [DIM_WIDTH-1:0]   src_width,
  input  logic [DIM_WIDTH-1:0]   src_height,
  input  logic [SCALE_WIDTH-1:0] scale_factor,
  output logic                   busy,
  output logic                   done,
  output logic                   err_cfg,
  output logic [31:0]            perf_active_cycles,
  output logic [31:0]            perf_stall_cycles,
  dsa_scan_scheduler_if.master   bus
);

  sched_state_t state, state_nx;

  logic [DIM_WIDTH-1:0]   src_w_q, src_h_q, dst_w_q, dst_h_q;
  logic [SCALE_WIDTH-1:0] scale_q;
  logic                   err_q, abort_pend_q;

  logic [PROD_WIDTH-1:0]  prod_w, prod_h;
  logic                   cfg_bad;

  logic [DIM_WIDTH-1:0]   walk_x, walk_y;
  logic [SIMD_WIDTH-1:0]  walk_mask;
  logic                   walk_last;
  logic                   advance;

  assign prod_w  = PROD_WIDTH'(src_w_q) * PROD_WIDTH'(scale_q);
  assign prod_h  = PROD_WIDTH'(src_h_q) * PROD_WIDTH'(scale_q);
  assign cfg_bad = (scale_q == '0) || (src_w_q == '0) || (src_h_q == '0) ||
                   (|prod_w[PROD_WIDTH-1:DIM_WIDTH]) || (|prod_h[PROD_WIDTH-1:DIM_WIDTH]);

  // Abort takes priority over a same-cycle acceptance, so an aborted group never transfers.
  assign advance = (state == S_EMIT) && bus.out_ready && !abort && !walk_last;

  dsa_raster_walker #(
    .SIMD_WIDTH (SIMD_WIDTH),
    .DIM_WIDTH  (DIM_WIDTH)
  ) u_walker (
    .clk       (clk),
    .rst       (rst),
    .clear     (state == S_CHECK),
    .advance   (advance),
    .dst_w     (dst_w_q),
    .dst_h     (dst_h_q),
    .x         (walk_x),
    .y         (walk_y),
    .lane_mask (walk_mask),
    .last      (walk_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx            = state;
    busy                = (state != S_IDLE);
    done                = (state == S_DONE);
    err_cfg             = (state == S_DONE) && err_q;
    bus.fetch_req_valid = (state == S_ISSUE) && !bus.fetch_busy;
    bus.fetch_base_x    = walk_x;
    bus.fetch_base_y    = walk_y;
    bus.out_valid       = (state == S_EMIT);
    bus.out_x           = '0;
    bus.out_y           = '0;
    bus.out_lane_mask   = '0;
    bus.out_last        = 1'b0;
    if (state == S_EMIT) begin
      bus.out_x         = walk_x;
      bus.out_y         = walk_y;
      bus.out_lane_mask = walk_mask;
      bus.out_last      = walk_last;
    end

    unique case (state)
      S_IDLE:  if (start) state_nx = S_CHECK;
      S_CHECK: state_nx = (abort || cfg_bad) ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        if (abort)                state_nx = S_DONE;
        else if (!bus.fetch_busy) state_nx = S_WAIT;
      end
      // The fetch unit cannot be cancelled, so an abort here waits for its completion.
      S_WAIT:  if (bus.fetch_valid) state_nx = (abort || abort_pend_q) ? S_DONE : S_EMIT;
      S_EMIT: begin
        if (abort)              state_nx = S_DONE;
        else if (bus.out_ready) state_nx = walk_last ? S_DONE : S_ISSUE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_w_q      <= '0;
      src_h_q      <= '0;
      scale_q      <= '0;
      dst_w_q      <= '0;
      dst_h_q      <= '0;
      err_q        <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          src_w_q <= src_width;
          src_h_q <= src_height;
          scale_q <= scale_factor;
        end
        S_CHECK: begin
          err_q   <= cfg_bad;
          dst_w_q <= prod_w[DIM_WIDTH-1:0];
          dst_h_q <= prod_h[DIM_WIDTH-1:0];
        end
        S_WAIT: if (abort) abort_pend_q <= 1'b1;
        S_DONE: begin
          err_q        <= 1'b0;
          abort_pend_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef DSA_SCAN_PERF_EN
  logic [31:0] active_q, stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= '0;
      stall_q  <= '0;
    end else if ((state == S_IDLE) && start) begin
      active_q <= '0;
      stall_q  <= '0;
    end else begin
      if ((state != S_IDLE) && (active_q != '1))
        active_q <= active_q + 32'd1;
      if ((state == S_EMIT) && !bus.out_ready && (stall_q != '1))
        stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_active_cycles = active_q;
  assign perf_stall_cycles  = stall_q;
`else
  assign perf_active_cycles = '0;
  assign perf_stall_cycles  = '0;
`endif

endmodule

// File: tb/tb_dsa_scan_scheduler.sv
// Scoreboard bench for dsa_scan_scheduler with a fixed-latency fetch unit model.
module tb_dsa_scan_scheduler;

  localparam int SW = 4;
  localparam int DW = 16;
`ifdef DSA_SCAN_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [SW-1:0] mask;
    logic          last;
  } grp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] src_width = '0;
  logic [DW-1:0] src_height = '0;
  logic [7:0]    scale_factor = '0;
  logic          busy, done, err_cfg;
  logic [31:0]   perf_active_cycles, perf_stall_cycles;

  logic          model_busy = 1'b0;
  logic          hold_busy = 1'b0;
  int            lat = 20;
  int            req_count = 0;
  int            done_seen = 0;
  int            total = 0;
  int            bad = 0;

  grp_t          exp_q[$];
  logic          exp_done[$];

  dsa_scan_scheduler_if #(.SIMD_WIDTH(SW), .DIM_WIDTH(DW)) bus ();

  assign bus.fetch_busy = model_busy | hold_busy;

  dsa_scan_scheduler #(.SIMD_WIDTH(SW), .DIM_WIDTH(DW)) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .abort              (abort),
    .src_width          (src_width),
    .src_height         (src_height),
    .scale_factor       (scale_factor),
    .busy               (busy),
    .done               (done),
    .err_cfg            (err_cfg),
    .perf_active_cycles (perf_active_cycles),
    .perf_stall_cycles  (perf_stall_cycles),
    .bus                (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not expected or not seen", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_grp(input int x, input int y, input logic [SW-1:0] m, input logic l);
    grp_t g;
    g.x = DW'(x); g.y = DW'(y); g.mask = m; g.last = l;
    exp_q.push_back(g);
  endtask

  task automatic push_8x4();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x += 4)
        push_grp(x, y, 4'b1111, (y == 3) && (x == 4));
  endtask

  task automatic push_6x2();
    push_grp(0, 0, 4'b1111, 1'b0);
    push_grp(4, 0, 4'b0011, 1'b0);
    push_grp(0, 1, 4'b1111, 1'b0);
    push_grp(4, 1, 4'b0011, 1'b1);
  endtask

  task automatic start_job(input int w, input int h, input int s, input logic exp_err);
    exp_done.push_back(exp_err);
    src_width    = DW'(w);
    src_height   = DW'(h);
    scale_factor = 8'(s);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int mark, input int budget, input string name);
    int n = 0;
    while (done_seen == mark && n < budget) begin
      tick();
      n++;
    end
    if (done_seen == mark) fail_now({name, "_timeout"});
  endtask

  task automatic wait_out_valid(input int budget, input string name);
    int n = 0;
    while (!bus.out_valid && n < budget) begin
      tick();
      n++;
    end
    if (!bus.out_valid) fail_now({name, "_timeout"});
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, {busy, done, err_cfg, bus.fetch_req_valid, bus.out_valid, bus.out_last}, 0);
    check({name, "_out"}, {bus.out_x, bus.out_y, bus.out_lane_mask}, 0);
    check({name, "_base"}, {bus.fetch_base_x, bus.fetch_base_y}, 0);
    check({name, "_perf"}, {perf_active_cycles, perf_stall_cycles}, 0);
  endtask

  // Fetch unit: picks up a request seen before an edge, completes after lat cycles.
  initial begin : fetch_model
    int   cnt;
    logic pend;
    logic req_now;
    cnt = 0;
    pend = 1'b0;
    bus.fetch_valid = 1'b0;
    forever begin
      @(negedge clk);
      req_now = bus.fetch_req_valid;
      if (rst) begin
        model_busy = 1'b0;
        bus.fetch_valid = 1'b0;
        pend = 1'b0;
      end else begin
        if (bus.fetch_valid) begin
          bus.fetch_valid = 1'b0;
          model_busy = 1'b0;
        end else if (model_busy) begin
          if (cnt <= 1) bus.fetch_valid = 1'b1;
          else cnt--;
        end else if (pend) begin
          pend = 1'b0;
          model_busy = 1'b1;
          cnt = lat;
        end
        if (req_now) begin
          pend = 1'b1;
          req_count++;
        end
      end
    end
  end

  // Monitor: every presented group must match the scoreboard head; acceptance pops it.
  initial begin : monitor
    grp_t g;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_group");
          end else begin
            g = exp_q[0];
            check($sformatf("group_%0d_%0d", g.x, g.y),
                  {bus.out_x, bus.out_y, bus.out_lane_mask, bus.out_last},
                  {g.x, g.y, g.mask, g.last});
            if (bus.out_ready) void'(exp_q.pop_front());
          end
        end
        if (done) begin
          if (exp_done.size() == 0) fail_now("unexpected_done");
          else check("done_err_cfg", err_cfg, exp_done.pop_front());
          done_seen++;
        end else if (err_cfg) begin
          fail_now("err_cfg_without_done");
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int mark;
    int r0;
    int n;
    bus.out_ready = 1'b0;

    // Reset state.
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // 4x2 scale 2 -> 8x4, 20-cycle fetch latency, downstream always ready.
    lat = 20;
    bus.out_ready = 1'b1;
    push_8x4();
    mark = done_seen;
    r0 = req_count;
    start_job(4, 2, 2, 1'b0);
    check("check_state_busy", busy, 1'b1);
    check("check_state_no_req", bus.fetch_req_valid, 1'b0);
    tick();
    check("issue_req_latency", bus.fetch_req_valid, 1'b1);
    wait_done(mark, 600, "job_8x4");
    check("job_8x4_requests", req_count - r0, 8);
    tick();

    // 3x1 scale 2 -> 6x2 with partial last column group.
    lat = 3;
    push_6x2();
    mark = done_seen;
    start_job(3, 1, 2, 1'b0);
    n = 0;
    while (!bus.fetch_valid && n < 50) begin
      tick();
      n++;
    end
    check("out_valid_after_fetch_valid", bus.out_valid, 1'b1);
    wait_done(mark, 200, "job_6x2");
    tick();

    // Configuration errors: done + err_cfg two cycles after start, no fetch request.
    for (int k = 0; k < 3; k++) begin
      int w, h, s;
      w = (k == 1) ? 0 : ((k == 2) ? 32'h8000 : 4);
      h = 2;
      s = (k == 0) ? 0 : 2;
      r0 = req_count;
      start_job(w, h, s, 1'b1);
      check($sformatf("cfg%0d_no_done_yet", k), done, 1'b0);
      tick();
      check($sformatf("cfg%0d_done_err", k), {done, err_cfg}, 2'b11);
      tick();
      check($sformatf("cfg%0d_no_req", k), req_count - r0, 0);
      check($sformatf("cfg%0d_perf_active", k), perf_active_cycles, PERF ? 2 : 0);
    end

    // Downstream stalls 5 cycles on group 2.
    bus.out_ready = 1'b0;
    push_8x4();
    mark = done_seen;
    start_job(4, 2, 2, 1'b0);
    for (int g = 0; g < 8; g++) begin
      wait_out_valid(100, $sformatf("stall_grp%0d", g));
      if (g == 2) repeat (5) tick();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    wait_done(mark, 50, "job_stall");
    tick();
    check("perf_stall", perf_stall_cycles, PERF ? 5 : 0);

    // Abort during WAIT: no group, done right after the fetch completes.
    lat = 6;
    bus.out_ready = 1'b1;
    mark = done_seen;
    start_job(4, 2, 2, 1'b0);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n = 0;
    while (!bus.fetch_valid && n < 50) begin
      tick();
      n++;
    end
    check("abort_wait_done", {done, bus.out_valid}, 2'b10);
    wait_done(mark, 10, "abort_wait");
    tick();

    // Abort during EMIT: group withdrawn, done next cycle.
    lat = 3;
    bus.out_ready = 1'b0;
    push_grp(0, 0, 4'b1111, 1'b0);
    mark = done_seen;
    start_job(4, 2, 2, 1'b0);
    wait_out_valid(50, "abort_emit");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    check("abort_emit_done", {done, bus.out_valid}, 2'b10);
    wait_done(mark, 10, "abort_emit");
    tick();

    // fetch_busy held in ISSUE, then reset during the fetch.
    hold_busy = 1'b1;
    r0 = req_count;
    start_job(4, 2, 2, 1'b0);
    void'(exp_done.pop_back());
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("held_busy_no_req%0d", k), {busy, bus.fetch_req_valid}, 2'b10);
      tick();
    end
    hold_busy = 1'b0;
    #1;
    check("released_busy_req", bus.fetch_req_valid, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_all_zero("mid_job_reset");
    tick();
    rst = 1'b0;
    tick();
    check("reset_req_count", req_count - r0, 1);

    // Recovery after reset.
    bus.out_ready = 1'b1;
    push_6x2();
    mark = done_seen;
    start_job(3, 1, 2, 1'b0);
    wait_done(mark, 200, "job_recover");
    tick();

    check("groups_left", exp_q.size(), 0);
    check("dones_left", exp_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
